// File: rtl/irq_ctrl8.sv
// irq_ctrl8: 8-channel interrupt controller with edge-latched pending bits,
// priority select and an ack/eoi handshake toward one consumer.
// Ports: iClk, iRst (async, active-high), iReq[7:0] (active-low requests),
//   iMask[7:0] (1 = masked), iEI (active-low enable), iAck, iEoi,
//   oIrq, oVec[2:0], oInService[7:0], oEO (active-low cascade out).
// Option: define IRQ_ROTATE_PRI_EN for rotating priority (pointer pPri).
module irq_ctrl8 (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    input  logic [7:0] iMask,
    input  logic       iEI,
    input  logic       iAck,
    input  logic       iEoi,
    output logic       oIrq,
    output logic [2:0] oVec,
    output logic [7:0] oInService,
    output logic       oEO
);

    typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

    state_t     state;
    state_t     stateNext;
    logic [7:0] reqPrev;
    logic [7:0] pending;
    logic [7:0] pendingNext;
    logic [7:0] clrMask;
    logic [7:0] fall;
    logic [7:0] cand;
    logic       anyCand;
    logic [2:0] winner;
    logic       irqNext;
    logic [2:0] vecNext;
    logic [7:0] inSvcNext;
    logic       eoNext;

    assign fall    = reqPrev & ~iReq;
    assign cand    = pending & ~iMask;
    assign anyCand = |cand;

`ifdef IRQ_ROTATE_PRI_EN
    logic [2:0] pPri;
    logic [2:0] pPriNext;
    logic [2:0] rotIdx;

    // Walk from lowest to highest priority so the last hit wins;
    // offset 0 from pPri is the highest priority.
    always_comb begin
        winner = '0;
        rotIdx = '0;
        for (int j = 7; j >= 0; j--) begin
            rotIdx = pPri - 3'(j);
            if (cand[rotIdx]) winner = rotIdx;
        end
    end
`else
    // Ascending scan: the highest-numbered candidate wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) winner = 3'(i);
        end
    end
`endif

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (!iEI && anyCand) stateNext = PEND;
            end
            PEND: begin
                if (iAck)                     stateNext = SERVICE;
                else if (iEI || iMask[oVec])  stateNext = IDLE;
            end
            SERVICE: begin
                if (iEoi) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        irqNext   = oIrq;
        vecNext   = oVec;
        inSvcNext = oInService;
        clrMask   = '0;
`ifdef IRQ_ROTATE_PRI_EN
        pPriNext  = pPri;
`endif
        unique case (state)
            IDLE: begin
                if (!iEI && anyCand) begin
                    vecNext = winner;
                    irqNext = 1'b1;
                end
            end
            PEND: begin
                if (iAck) begin
                    clrMask   = 8'b1 << oVec;
                    inSvcNext = 8'b1 << oVec;
                    irqNext   = 1'b0;
                end else if (iEI || iMask[oVec]) begin
                    irqNext = 1'b0;
                end
            end
            SERVICE: begin
                if (iEoi) begin
                    inSvcNext = '0;
`ifdef IRQ_ROTATE_PRI_EN
                    pPriNext  = oVec - 3'd1;
`endif
                end
            end
            default: irqNext = 1'b0;
        endcase
        // A new falling edge beats a same-cycle ack clear.
        pendingNext = (pending & ~clrMask) | fall;
        eoNext      = !(!iEI && (state == IDLE) && !anyCand);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            reqPrev    <= 8'hFF;
            pending    <= '0;
            oIrq       <= 1'b0;
            oVec       <= '0;
            oInService <= '0;
            oEO        <= 1'b1;
`ifdef IRQ_ROTATE_PRI_EN
            pPri       <= 3'd7;
`endif
        end else begin
            reqPrev    <= iReq;
            pending    <= pendingNext;
            oIrq       <= irqNext;
            oVec       <= vecNext;
            oInService <= inSvcNext;
            oEO        <= eoNext;
`ifdef IRQ_ROTATE_PRI_EN
            pPri       <= pPriNext;
`endif
        end
    end

endmodule

// File: tb/tb_irq_ctrl8.sv
// tb_irq_ctrl8: directed plus random checks of irq_ctrl8
// against a behavioural model of the controller.
module tb_irq_ctrl8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ei;
    logic       ack;
    logic       eoi;
    logic       oIrq;
    logic [2:0] oVec;
    logic [7:0] oInService;
    logic       oEO;

    int nAsserts = 0;
    int nFail    = 0;

    // Model state: mSt 0 = idle, 1 = presenting, 2 = in service
    int         mSt;
    bit [7:0]   mPend;
    bit [7:0]   mPrev;
    bit         mIrq;
    bit [2:0]   mVec;
    bit [7:0]   mIsv;
    bit         mEO;
    int         mPri;

    irq_ctrl8 dut (
        .iClk       (clk),
        .iRst       (rst),
        .iReq       (req),
        .iMask      (mask),
        .iEI        (ei),
        .iAck       (ack),
        .iEoi       (eoi),
        .oIrq       (oIrq),
        .oVec       (oVec),
        .oInService (oInService),
        .oEO        (oEO)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mReset();
        mSt   = 0;
        mPend = '0;
        mPrev = 8'hFF;
        mIrq  = 0;
        mVec  = 0;
        mIsv  = 0;
        mEO   = 1;
        mPri  = 7;
    endtask

    // First candidate found walking down from the top-priority channel.
    function automatic int pick(bit [7:0] c, int top);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (top - k + 8) % 8;
            if (c[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic mStep();
        bit [7:0] fall;
        bit [7:0] cand;
        int       top;
        fall = mPrev & ~req;
        cand = mPend & ~mask;
        mEO  = !(ei == 0 && mSt == 0 && cand == 0);
`ifdef IRQ_ROTATE_PRI_EN
        top = mPri;
`else
        top = 7;
`endif
        if (mSt == 0) begin
            if (ei == 0 && cand != 0) begin
                mVec = 3'(pick(cand, top));
                mIrq = 1;
                mSt  = 1;
            end
        end else if (mSt == 1) begin
            if (ack) begin
                mPend[mVec] = 0;
                mIsv = '0;
                mIsv[mVec] = 1;
                mIrq = 0;
                mSt  = 2;
            end else if (ei || mask[mVec]) begin
                mIrq = 0;
                mSt  = 0;
            end
        end else begin
            if (eoi) begin
                mIsv = 0;
                mSt  = 0;
                mPri = (int'(mVec) + 7) % 8;
            end
        end
        mPend = mPend | fall;
        mPrev = req;
    endtask

    task automatic tick();
        @(posedge clk);
        mStep();
        @(negedge clk);
        chk("irq", {7'b0, oIrq}, {7'b0, mIrq});
        chk("vec", {5'b0, oVec}, {5'b0, mVec});
        chk("insvc", oInService, mIsv);
        chk("eo", {7'b0, oEO}, {7'b0, mEO});
    endtask

    task automatic ackPulse();
        ack = 1;
        tick();
        ack = 0;
    endtask

    task automatic eoiPulse();
        eoi = 1;
        tick();
        eoi = 0;
    endtask

    task automatic serve();
        ackPulse();
        eoiPulse();
    endtask

    initial begin
        rst  = 1;
        req  = 8'hFF;
        mask = 8'h00;
        ei   = 0;
        ack  = 0;
        eoi  = 0;
        mReset();
        #1;
        chk("rst_irq", {7'b0, oIrq}, 8'h00);
        chk("rst_vec", {5'b0, oVec}, 8'h00);
        chk("rst_isv", oInService, 8'h00);
        chk("rst_eo", {7'b0, oEO}, 8'h01);
        @(negedge clk);
        rst = 0;
        tick();

        // single request on channel 0, two-edge latency
        req = 8'hFE;
        tick();
        chk("t1_lat", {7'b0, oIrq}, 8'h00);
        tick();
        chk("t1_irq", {7'b0, oIrq}, 8'h01);
        chk("t1_vec", {5'b0, oVec}, 8'h00);
        ackPulse();
        chk("t1_isv", oInService, 8'h01);
        eoiPulse();
        chk("t1_eoi", oInService, 8'h00);
        tick();
        chk("t1_eo", {7'b0, oEO}, 8'h00);
        req = 8'hFF;
        tick();

        // channels 7 and 4 together
        req = 8'h6F;
        tick();
        tick();
        chk("t2_vec7", {5'b0, oVec}, 8'h07);
        serve();
        tick();
        chk("t2_vec4", {5'b0, oVec}, 8'h04);
        serve();
        req = 8'hFF;
        tick();

        // no preemption while presenting
        req = 8'hFB;
        tick();
        tick();
        chk("t3_vec2", {5'b0, oVec}, 8'h02);
        req = 8'hDB;
        tick();
        chk("t3_hold", {5'b0, oVec}, 8'h02);
        serve();
        tick();
        chk("t3_vec5", {5'b0, oVec}, 8'h05);
        serve();
        req = 8'hFF;
        tick();

        // mask withdraws, pending kept
        req = 8'hFB;
        tick();
        tick();
        mask = 8'h04;
        tick();
        chk("t3_wdraw", {7'b0, oIrq}, 8'h00);
        mask = 8'h00;
        tick();
        chk("t3_reirq", {7'b0, oIrq}, 8'h01);
        chk("t3_revec", {5'b0, oVec}, 8'h02);
        serve();
        req = 8'hFF;
        tick();

        // global disable
        ei  = 1;
        req = 8'hF5;
        tick();
        tick();
        tick();
        chk("t4_irq", {7'b0, oIrq}, 8'h00);
        chk("t4_eo", {7'b0, oEO}, 8'h01);
        ei = 0;
        tick();
        chk("t4_en", {7'b0, oIrq}, 8'h01);
`ifdef IRQ_ROTATE_PRI_EN
        chk("t4_vec", {5'b0, oVec}, 8'h01);
`else
        chk("t4_vec", {5'b0, oVec}, 8'h03);
`endif
        serve();
        tick();
        serve();
        req = 8'hFF;
        tick();

        // serve 7, then 7 and 0 together
        req = 8'h7F;
        tick();
        tick();
        chk("t5_vec7", {5'b0, oVec}, 8'h07);
        serve();
        req = 8'hFF;
        tick();
        req = 8'h7E;
        tick();
        tick();
`ifdef IRQ_ROTATE_PRI_EN
        chk("t5_rot", {5'b0, oVec}, 8'h00);
`else
        chk("t5_rot", {5'b0, oVec}, 8'h07);
`endif
        serve();
        tick();
`ifdef IRQ_ROTATE_PRI_EN
        chk("t5_next", {5'b0, oVec}, 8'h07);
`else
        chk("t5_next", {5'b0, oVec}, 8'h00);
`endif
        serve();
        req = 8'hFF;
        tick();

        // async reset during service
        req = 8'hF7;
        tick();
        tick();
        ackPulse();
        chk("t6_svc", oInService, 8'h08);
        #2;
        rst = 1;
        #1;
        chk("t6_irq", {7'b0, oIrq}, 8'h00);
        chk("t6_vec", {5'b0, oVec}, 8'h00);
        chk("t6_isv", oInService, 8'h00);
        chk("t6_eo", {7'b0, oEO}, 8'h01);
        mReset();
        req = 8'hFF;
        @(negedge clk);
        rst = 0;
        tick();
        tick();
        chk("t6_quiet", {7'b0, oIrq}, 8'h00);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) req = req ^ 8'($urandom);
            mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            ei   = ($urandom_range(0, 9) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            eoi  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFail);
        $finish;
    end

endmodule
